systolic_gemm_tile: RTL and testbench
=====================================

# systolic_gemm_tile

Parametrised FP systolic GEMM tile: wraps an ARR_HEIGHT x ARR_WIDTH grid of processing_element MAC cells with the control the bare array lacks. This includes input skewing, accumulator clear, a K-step counter, pipeline flush and a row-serial result drain with valid/ready handshakes. It sits between the operand buffers and the result writeback path, so upstream logic streams unskewed A columns and B rows and never tracks wavefront timing.

## Interface
- WIDTH, 16, element width (FP, 1 sign + EXP_BITS + FRAC_BITS)
- EXP_BITS, 5, exponent bits
- FRAC_BITS, 10, fraction bits
- ARR_HEIGHT, 4, PE rows (output rows, M)
- ARR_WIDTH, 4, PE columns (output columns, N)
- MAX_K, 256, largest supported K; KW = $clog2(MAX_K+1)
- clk  in  1  clock; everything on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin job; sampled only in IDLE
- k_len  in  KW  K steps for the job, sampled with start; values above MAX_K are illegal
- in_valid  in  1  operand beat valid
- in_ready  out  1  tile accepts beat
- in_a  in  ARR_HEIGHT*WIDTH  A column k; lane i feeds row i
- in_b  in  ARR_WIDTH*WIDTH  B row k; lane j feeds column j
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts row
- out_row  out  ARR_WIDTH*WIDTH  C[r][0..N-1]; lane j = column j
- out_row_idx  out  max(1,$clog2(ARR_HEIGHT))  row index r
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after last row accepted

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE -> LOAD on start when k_len > 0. IDLE -> FLUSH on start when k_len = 0; the result is all +0.
- The start cycle pulses an internal accumulator clear to every PE and loads the K counter.
- LOAD: in_ready = 1. Each cycle with in_valid && in_ready is one k-step and decrements the counter. The last beat moves the FSM to FLUSH.
- Skew: row lane i is delayed i cycles and column lane j is delayed j cycles by shift registers. Cycles without an accepted beat inject +0 into all lanes, so stalls keep wavefronts aligned and add only 0*0.
- FLUSH: inject zeros for exactly ARR_HEIGHT+ARR_WIDTH-1 cycles (skew depth plus the PE register), then go to DRAIN.
- DRAIN: present row r = 0..ARR_HEIGHT-1. Advance r on out_valid && out_ready. After row ARR_HEIGHT-1 is accepted, pulse done and return to IDLE.
- Arithmetic: the PE multiply-accumulate is FP with per-PE rounding. This block adds no arithmetic except the optional ReLU.
- start while busy is ignored. in_valid outside LOAD is ignored (in_ready = 0).

## Timing
- Reset values: in_ready 0, out_valid 0, out_row 0, out_row_idx 0, busy 0, done 0. Skew registers, FSM and counters return to IDLE/0.
- busy rises the cycle after start is sampled. in_ready is first high that cycle.
- With no stalls, first out_valid comes K + ARR_HEIGHT + ARR_WIDTH - 1 cycles after the LOAD entry cycle.
- Drain throughput is one row per cycle with out_ready held high. The full drain takes ARR_HEIGHT cycles.
- out_row and out_row_idx are registered and hold stable while out_valid && !out_ready.
- done is asserted in the cycle after the final handshake. busy falls in the same cycle.
- Reset asserted mid-job aborts immediately and asynchronously. No partial results are emitted after release.

## Configuration
- SA_OUT_RELU_EN: when defined, each out_row lane with the sign bit set (including -0) is replaced by +0 before the output register.
- When not defined, raw accumulator values pass through unchanged.

## Test plan
- Identity: A = I (1.0 = 16'h3C00), B row k = {k+1} in FP16, K = 4 -> row r = B row r; out_row_idx 0..3; done 1 cycle.
- All-2.0 operands (16'h4000), K = 8 -> every lane 16'h5000 (32.0); first out_valid at cycle K+7 from LOAD entry.
- Random in_valid gaps (50%) on the identity case -> identical results to the no-stall run; in_ready low outside LOAD.
- out_ready toggled 1/0 during DRAIN -> each row seen exactly once, held stable across stalls, done after row 3.
- k_len = 0 -> skip LOAD, all lanes 16'h0000. start during DRAIN ignored. Reset at mid-LOAD -> all outputs 0, IDLE; the next job gives correct results (accumulators cleared).
- SA_OUT_RELU_EN with A = -1.0 (16'hBC00), B = 1.0, K = 2 -> lanes 16'h0000. Without the macro -> 16'hC000.

Source files
------------

// File: rtl/systolic_gemm_tile.sv
// systolic_gemm_tile: FP systolic GEMM tile with input skew, flush and row drain.
// Optional macro SA_OUT_RELU_EN clamps sign-set result lanes to +0.

module processing_element #(
    parameter int WIDTH     = 16,
    parameter int EXP_BITS  = 5,
    parameter int FRAC_BITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] acc
);
    localparam int F    = FRAC_BITS;
    localparam int EB   = EXP_BITS;
    localparam int MW   = 2*F + 2;
    localparam int XW   = MW + 3;
    localparam int SW   = XW + 1;
    localparam int EW   = EB + 4;
    localparam int BIAS = (1 << (EB-1)) - 1;
    localparam int EMAX = (1 << EB) - 1;
    localparam logic signed [EW-1:0] EZERO = '0;

    logic                 skip;
    logic [WIDTH-1:0]     res;
    logic [MW-1:0]        pm, cm, bm, sm;
    logic signed [EW-1:0] pexp, cexp, bexp, sexp, dexp, rexp;
    logic                 ps, pbig, bsg, ssg, g, st;
    logic [XW-1:0]        xb, xs, al;
    logic [SW-1:0]        sum, nrm;
    logic [F:0]           mant;
    logic [F+1:0]         rnd;
    int                   msb;

    // Fused a*b + acc: exact product, aligned add, single RNE rounding, FTZ.
    always_comb begin
        ps   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
        pm   = MW'({1'b1, a_in[F-1:0]}) * MW'({1'b1, b_in[F-1:0]});
        pexp = EW'(a_in[WIDTH-2:F]) + EW'(b_in[WIDTH-2:F])
             - EW'(BIAS) + EW'(1);
        if (!pm[MW-1]) begin
            pm   = pm << 1;
            pexp = pexp - EW'(1);
        end
        skip = (a_in[WIDTH-2:F] == '0) || (b_in[WIDTH-2:F] == '0)
            || (pexp <= EZERO);
        cexp = EW'(acc[WIDTH-2:F]);
        cm   = (acc[WIDTH-2:F] == '0) ? '0
             : {1'b1, acc[F-1:0], {(F+1){1'b0}}};
        pbig = (pexp > cexp) || ((pexp == cexp) && (pm >= cm));
        bm   = pbig ? pm : cm;
        sm   = pbig ? cm : pm;
        bexp = pbig ? pexp : cexp;
        sexp = pbig ? cexp : pexp;
        bsg  = pbig ? ps : acc[WIDTH-1];
        ssg  = pbig ? acc[WIDTH-1] : ps;
        dexp = bexp - sexp;
        xb   = {bm, 3'b000};
        xs   = {sm, 3'b000};
        if (dexp >= EW'(XW)) begin
            al = {{(XW-1){1'b0}}, |xs};
        end else begin
            al = xs >> dexp[EW-1:0];
            if ((al << dexp[EW-1:0]) != xs) al[0] = 1'b1;
        end
        sum = (bsg == ssg) ? ({1'b0, xb} + {1'b0, al})
                           : ({1'b0, xb} - {1'b0, al});
        msb = 0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) msb = i;
        end
        nrm  = sum << (SW - 1 - msb);
        rexp = bexp + EW'(1) - EW'(SW - 1 - msb);
        mant = nrm[SW-1 -: F+1];
        g    = nrm[SW-F-2];
        st   = |nrm[SW-F-3:0];
        rnd  = {1'b0, mant} + (F+2)'(g && (st || mant[0]));
        if (rnd[F+1]) begin
            mant = rnd[F+1:1];
            rexp = rexp + EW'(1);
        end else begin
            mant = rnd[F:0];
        end
        if (sum == '0)
            res = '0;
        else if (rexp <= EZERO)
            res = {bsg, {(WIDTH-1){1'b0}}};
        else if (rexp >= EW'(EMAX))
            res = {bsg, {EB{1'b1}}, {F{1'b0}}};
        else
            res = {bsg, rexp[EB-1:0], mant[F-1:0]};
    end

    // Pass operands on to neighbours and accumulate non-zero products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clr)
                acc <= '0;
            else if (!skip)
                acc <= res;
        end
    end
endmodule

module systolic_gemm_tile #(
    parameter  int WIDTH      = 16,
    parameter  int EXP_BITS   = 5,
    parameter  int FRAC_BITS  = 10,
    parameter  int ARR_HEIGHT = 4,
    parameter  int ARR_WIDTH  = 4,
    parameter  int MAX_K      = 256,
    localparam int KW         = $clog2(MAX_K + 1),
    localparam int IW         = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ARR_HEIGHT*WIDTH-1:0] in_a,
    input  logic [ARR_WIDTH*WIDTH-1:0]  in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ARR_WIDTH*WIDTH-1:0]  out_row,
    output logic [IW-1:0]             out_row_idx,
    output logic                      busy,
    output logic                      done
);
    localparam int FLUSH_LEN = ARR_HEIGHT + ARR_WIDTH - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t         state;
    logic [KW-1:0]  kcnt;
    logic [FW-1:0]  fcnt;
    logic           take;
    logic           clr;

    logic [WIDTH-1:0] a_edge [ARR_HEIGHT];
    logic [WIDTH-1:0] b_edge [ARR_WIDTH];
    logic [WIDTH-1:0] a_pass [ARR_HEIGHT][ARR_WIDTH];
    logic [WIDTH-1:0] b_pass [ARR_HEIGHT][ARR_WIDTH];
    logic [WIDTH-1:0] acc_g  [ARR_HEIGHT][ARR_WIDTH];
    logic [ARR_WIDTH*WIDTH-1:0] row_vec [ARR_HEIGHT];

    assign take = in_valid && in_ready;
    assign clr  = (state == IDLE) && start;

    function automatic logic [WIDTH-1:0] lane_out(input logic [WIDTH-1:0] v);
`ifdef SA_OUT_RELU_EN
        return v[WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    for (genvar gi = 0; gi < ARR_HEIGHT; gi++) begin : g_askew
        logic [WIDTH-1:0] lane;
        assign lane = take ? in_a[gi*WIDTH +: WIDTH] : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = lane;
        end else begin : g_delay
            logic [WIDTH-1:0] sr [gi];
            // Delay row lane gi by gi cycles so wavefronts meet diagonally.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int d = 0; d < gi; d++) sr[d] <= '0;
                end else begin
                    sr[0] <= lane;
                    for (int d = 1; d < gi; d++) sr[d] <= sr[d-1];
                end
            end
            assign a_edge[gi] = sr[gi-1];
        end
    end

    for (genvar gj = 0; gj < ARR_WIDTH; gj++) begin : g_bskew
        logic [WIDTH-1:0] lane;
        assign lane = take ? in_b[gj*WIDTH +: WIDTH] : '0;
        if (gj == 0) begin : g_direct
            assign b_edge[gj] = lane;
        end else begin : g_delay
            logic [WIDTH-1:0] sr [gj];
            // Delay column lane gj by gj cycles so wavefronts meet diagonally.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int d = 0; d < gj; d++) sr[d] <= '0;
                end else begin
                    sr[0] <= lane;
                    for (int d = 1; d < gj; d++) sr[d] <= sr[d-1];
                end
            end
            assign b_edge[gj] = sr[gj-1];
        end
    end

    for (genvar gr = 0; gr < ARR_HEIGHT; gr++) begin : g_row
        for (genvar gc = 0; gc < ARR_WIDTH; gc++) begin : g_col
            logic [WIDTH-1:0] a_src, b_src;
            if (gc == 0) begin : g_aw
                assign a_src = a_edge[gr];
            end else begin : g_an
                assign a_src = a_pass[gr][gc-1];
            end
            if (gr == 0) begin : g_bw
                assign b_src = b_edge[gc];
            end else begin : g_bn
                assign b_src = b_pass[gr-1][gc];
            end
            processing_element #(
                .WIDTH    (WIDTH),
                .EXP_BITS (EXP_BITS),
                .FRAC_BITS(FRAC_BITS)
            ) u_pe (
                .clk  (clk),
                .reset(reset),
                .clr  (clr),
                .a_in (a_src),
                .b_in (b_src),
                .a_out(a_pass[gr][gc]),
                .b_out(b_pass[gr][gc]),
                .acc  (acc_g[gr][gc])
            );
            assign row_vec[gr][gc*WIDTH +: WIDTH] = lane_out(acc_g[gr][gc]);
        end
    end

    // Job control: load K beats, flush the skew, then drain rows serially.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            kcnt        <= '0;
            fcnt        <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        kcnt <= k_len;
                        busy <= 1'b1;
                        if (k_len == '0) begin
                            state <= FLUSH;
                            fcnt  <= FW'(FLUSH_LEN);
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (take) begin
                        kcnt <= kcnt - 1'b1;
                        if (kcnt == KW'(1)) begin
                            in_ready <= 1'b0;
                            state    <= FLUSH;
                            fcnt     <= FW'(FLUSH_LEN);
                        end
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt - 1'b1;
                    if (fcnt == FW'(1)) begin
                        state       <= DRAIN;
                        out_valid   <= 1'b1;
                        out_row     <= row_vec[0];
                        out_row_idx <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_row_idx == IW'(ARR_HEIGHT - 1)) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_row_idx <= out_row_idx + 1'b1;
                            out_row     <= row_vec[out_row_idx + 1'b1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_gemm_tile.sv
// tb_systolic_gemm_tile: directed checks of the 4x4 FP16 systolic tile.
// Covers reset, identity, all-2.0, stalls, k_len=0, mid-job reset, ReLU.

module tb_systolic_gemm_tile;
    localparam int W  = 16;
    localparam int H  = 4;
    localparam int N  = 4;
    localparam int KW = 9;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [KW-1:0]  k_len = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [H*W-1:0] in_a = '0;
    logic [N*W-1:0] in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] out_row;
    logic [IW-1:0]  out_row_idx;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [N*W-1:0] got_row [4];
    int got_idx [4];
    int got_n;

    always #5 clk = ~clk;

    systolic_gemm_tile dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_len      (k_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_row_idx(out_row_idx),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [15:0] fp_int(input int v);
        case (v)
            1: return 16'h3C00;
            2: return 16'h4000;
            3: return 16'h4200;
            4: return 16'h4400;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [N*W-1:0] rep(input logic [15:0] v);
        logic [N*W-1:0] r;
        for (int j = 0; j < N; j++) r[j*W +: W] = v;
        return r;
    endfunction

    function automatic logic [H*W-1:0] beat_a(input int kind, input int k);
        logic [H*W-1:0] r;
        for (int i = 0; i < H; i++) begin
            case (kind)
                0: r[i*W +: W] = (i == k) ? 16'h3C00 : 16'h0000;
                1: r[i*W +: W] = 16'h4000;
                default: r[i*W +: W] = 16'hBC00;
            endcase
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] beat_b(input int kind, input int k);
        case (kind)
            0: return rep(fp_int(k + 1));
            1: return rep(16'h4000);
            default: return rep(16'h3C00);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic feed(input int kind, input int k, input bit gaps);
        int got;
        bit acc;
        got = 0;
        for (int c = 0; c < 2000 && got < k; c++) begin
            in_valid = gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
            in_a = beat_a(kind, got);
            in_b = beat_b(kind, got);
            acc = in_valid && in_ready;
            tick();
            if (acc) got++;
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic wait_out();
        for (int c = 0; c < 500 && !out_valid; c++) tick();
    endtask

    task automatic capture(input bit toggle);
        got_n = 0;
        for (int c = 0; c < 100 && got_n < 4; c++) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (out_valid && out_ready) begin
                got_row[got_n] = out_row;
                got_idx[got_n] = int'(out_row_idx);
                got_n++;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_row !== '0) begin
            errors++; $display("FAIL rst_out_row: got %h want 0", out_row);
        end
        checks++;
        if (out_row_idx !== '0) begin
            errors++; $display("FAIL rst_idx: got %0d want 0", out_row_idx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rst_done: got %b want 0", done);
        end
    endtask

    task automatic test_identity();
        start_job(4);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL id_load_entry: got busy=%b in_ready=%b want 1 1",
                     busy, in_ready);
        end
        feed(0, 4, 1'b0);
        wait_out();
        checks++;
        if (cyc !== 11) begin
            errors++; $display("FAIL id_latency: got %0d want 11", cyc);
        end
        capture(1'b0);
        checks++;
        if (got_n !== 4) begin
            errors++; $display("FAIL id_rows: got %0d want 4", got_n);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_row[r] !== rep(fp_int(r + 1)) || got_idx[r] !== r) begin
                errors++;
                $display("FAIL id_row%0d: got %h idx %0d want %h idx %0d",
                         r, got_row[r], got_idx[r], rep(fp_int(r + 1)), r);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL id_done: got done=%b busy=%b want 1 0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL id_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_all_two();
        start_job(8);
        feed(1, 8, 1'b0);
        wait_out();
        checks++;
        if (cyc !== 15) begin
            errors++; $display("FAIL two_latency: got %0d want 15", cyc);
        end
        capture(1'b0);
        checks++;
        if (got_n !== 4) begin
            errors++; $display("FAIL two_rows: got %0d want 4", got_n);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_row[r] !== rep(16'h5000)) begin
                errors++;
                $display("FAIL two_row%0d: got %h want %h",
                         r, got_row[r], rep(16'h5000));
            end
        end
        tick();
    endtask

    task automatic test_in_stall();
        in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got in_ready=%b busy=%b want 0 0",
                     in_ready, busy);
        end
        in_valid = 1'b0;
        start_job(4);
        feed(0, 4, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b want 0", in_ready);
        end
        wait_out();
        capture(1'b0);
        checks++;
        if (got_n !== 4) begin
            errors++; $display("FAIL stall_rows: got %0d want 4", got_n);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_row[r] !== rep(fp_int(r + 1))) begin
                errors++;
                $display("FAIL stall_row%0d: got %h want %h",
                         r, got_row[r], rep(fp_int(r + 1)));
            end
        end
        tick();
    endtask

    task automatic test_out_stall();
        logic [N*W-1:0] held;
        logic [IW-1:0] hidx;
        bit have;
        int seen;
        have = 1'b0;
        seen = 0;
        held = '0;
        hidx = '0;
        start_job(4);
        feed(0, 4, 1'b0);
        wait_out();
        for (int c = 0; c < 100 && seen < 4; c++) begin
            out_ready = (c % 2 == 1);
            if (out_valid && !out_ready) begin
                held = out_row;
                hidx = out_row_idx;
                have = 1'b1;
            end else if (out_valid && out_ready) begin
                checks++;
                if (have && (out_row !== held || out_row_idx !== hidx)) begin
                    errors++;
                    $display("FAIL hold%0d: got %h/%0d want %h/%0d",
                             seen, out_row, out_row_idx, held, hidx);
                end
                checks++;
                if (out_row !== rep(fp_int(seen + 1)) ||
                    int'(out_row_idx) !== seen) begin
                    errors++;
                    $display("FAIL ostall_row%0d: got %h idx %0d want %h",
                             seen, out_row, out_row_idx, rep(fp_int(seen + 1)));
                end
                seen++;
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 4 || done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ostall_end: got rows=%0d done=%b valid=%b want 4 1 0",
                     seen, done, out_valid);
        end
        tick();
    endtask

    task automatic test_k_zero();
        start_job(0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL k0_entry: got busy=%b in_ready=%b want 1 0",
                     busy, in_ready);
        end
        wait_out();
        checks++;
        if (cyc !== 7) begin
            errors++; $display("FAIL k0_latency: got %0d want 7", cyc);
        end
        start = 1'b1;
        k_len = KW'(4);
        tick();
        start = 1'b0;
        capture(1'b0);
        checks++;
        if (got_n !== 4) begin
            errors++; $display("FAIL k0_rows: got %0d want 4", got_n);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_row[r] !== '0) begin
                errors++; $display("FAIL k0_row%0d: got %h want 0", r, got_row[r]);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL k0_start_ignored: got busy=%b in_ready=%b want 0 0",
                     busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        start_job(4);
        feed(1, 2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_row !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b rdy=%b vld=%b row=%h done=%b want all 0",
                     busy, in_ready, out_valid, out_row, done);
        end
        tick();
        reset = 1'b0;
        tick();
        start_job(4);
        feed(0, 4, 1'b0);
        wait_out();
        capture(1'b0);
        checks++;
        if (got_n !== 4) begin
            errors++; $display("FAIL post_rst_rows: got %0d want 4", got_n);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_row[r] !== rep(fp_int(r + 1))) begin
                errors++;
                $display("FAIL post_rst_row%0d: got %h want %h",
                         r, got_row[r], rep(fp_int(r + 1)));
            end
        end
        tick();
    endtask

    task automatic test_relu();
        logic [N*W-1:0] want;
`ifdef SA_OUT_RELU_EN
        want = '0;
`else
        want = rep(16'hC000);
`endif
        start_job(2);
        feed(2, 2, 1'b0);
        wait_out();
        capture(1'b0);
        checks++;
        if (got_n !== 4) begin
            errors++; $display("FAIL neg_rows: got %0d want 4", got_n);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_row[r] !== want) begin
                errors++;
                $display("FAIL neg_row%0d: got %h want %h", r, got_row[r], want);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_two();
        test_in_stall();
        test_out_stall();
        test_k_zero();
        test_reset_mid();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
